// File: rtl/yazmac_skor_tablosu.sv
// Register scoreboard for the back end.
// Tracks destination registers owned by long-latency execute units and stalls
// decode/register-read on RAW, WAW and per-unit capacity hazards. A completion
// in the current cycle releases its register combinationally, because
// write-back writes through the register file in that same cycle.
`timescale 1ns/1ps

module yazmac_skor_tablosu #(
    parameter int YAZMAC_SAYISI = 32,
    parameter int ADRES_BIT     = 5,
    parameter int BIRIM_SAYISI  = 3,
    parameter int BIRIM_BIT     = 2,
    parameter int MAKS_BEKLEYEN = 4,
    parameter int SAYAC_BIT     = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              cyo_gecerli_i,
    input  logic [ADRES_BIT-1:0]              cyo_rs1_adres_i,
    input  logic                              cyo_rs1_kullan_i,
    input  logic [ADRES_BIT-1:0]              cyo_rs2_adres_i,
    input  logic                              cyo_rs2_kullan_i,
    input  logic [ADRES_BIT-1:0]              cyo_rd_adres_i,
    input  logic                              cyo_rd_yaz_i,
    input  logic [BIRIM_BIT-1:0]              cyo_birim_i,
    input  logic                              ddb_durdur_i,
    input  logic                              ddb_bosalt_i,
    output logic                              cyo_durdur_o,
    output logic                              cyo_yayin_o,
    input  logic [BIRIM_SAYISI-1:0]           gy_tamam_i,
    input  logic [BIRIM_SAYISI*ADRES_BIT-1:0] gy_rd_adres_i,
    output logic [BIRIM_SAYISI*SAYAC_BIT-1:0] bekleyen_sayisi_o,
    output logic                              bos_o,
    output logic                              hata_o
);

    // Tables are sized to the full address space so that any address indexes
    // in range; entries at or above YAZMAC_SAYISI are simply never set.
    localparam int DERIN = 1 << ADRES_BIT;
    localparam logic [SAYAC_BIT-1:0] SAYAC_MAKS = SAYAC_BIT'(MAKS_BEKLEYEN);
    localparam logic [SAYAC_BIT-1:0] SAYAC_BIR  = SAYAC_BIT'(1);

    // Scoreboard state
    logic [DERIN-1:0]     bekliyor_q, bekliyor_d;
    logic [BIRIM_BIT-1:0] sahip_q [DERIN];
    logic [BIRIM_BIT-1:0] sahip_d [DERIN];
    logic [SAYAC_BIT-1:0] sayac_q [BIRIM_SAYISI];
    logic [SAYAC_BIT-1:0] sayac_d [BIRIM_SAYISI];
    logic                 hata_q, hata_d;
    logic                 bos_q, bos_d;

    // Per-unit completion decode (array index k-1 belongs to unit k)
    logic [ADRES_BIT-1:0]    gy_rd [BIRIM_SAYISI];
    logic [BIRIM_SAYISI-1:0] sahip_uyusuyor;
    logic [BIRIM_SAYISI-1:0] sahip_hatasi;
    logic [BIRIM_SAYISI-1:0] bos_sayac_hatasi;
    logic [BIRIM_SAYISI-1:0] tamam_gecerli;

    // Per-register readiness
    logic [DERIN-1:0] tamamlaniyor;
    logic [DERIN-1:0] hazir;

    // Decode-side hazard terms
    logic birim_gecerli;
    logic birim_hatasi;
    logic rd_izlenir;
    logic raw_rs1, raw_rs2, waw;
    logic kapasite_dolu;
    logic durdur_ham;
    logic yayin;

    genvar gi;
    generate
        for (gi = 0; gi < BIRIM_SAYISI; gi++) begin : g_birim
            assign gy_rd[gi] = gy_rd_adres_i[gi*ADRES_BIT +: ADRES_BIT];

            // Completion releases its register only when this unit owns it.
            assign sahip_uyusuyor[gi] = gy_tamam_i[gi]
                                      && (gy_rd[gi] != '0)
                                      && bekliyor_q[gy_rd[gi]]
                                      && (sahip_q[gy_rd[gi]] == BIRIM_BIT'(gi + 1));

            // Completion naming a register that another unit is waiting on.
            assign sahip_hatasi[gi] = gy_tamam_i[gi]
                                    && (gy_rd[gi] != '0)
                                    && bekliyor_q[gy_rd[gi]]
                                    && (sahip_q[gy_rd[gi]] != BIRIM_BIT'(gi + 1));

            // Completion from a unit with nothing outstanding (e.g. stale after reset).
            assign bos_sayac_hatasi[gi] = gy_tamam_i[gi] && (sayac_q[gi] == '0);

            // Only well-formed completions decrement the unit's counter.
            assign tamam_gecerli[gi] = gy_tamam_i[gi]
                                     && !bos_sayac_hatasi[gi]
                                     && !sahip_hatasi[gi];

            assign bekleyen_sayisi_o[gi*SAYAC_BIT +: SAYAC_BIT] = sayac_q[gi];
        end
    endgenerate

    // Collect owner-matched completions into a per-register release mask.
    always_comb begin
        tamamlaniyor = '0;
        for (int k = 0; k < BIRIM_SAYISI; k++) begin
            if (sahip_uyusuyor[k]) begin
                tamamlaniyor[gy_rd[k]] = 1'b1;
            end
        end
    end

    assign hazir = ~bekliyor_q | tamamlaniyor;

    // Classify the instruction sitting in decode.
    always_comb begin
        birim_gecerli = (cyo_birim_i != '0) && (int'(cyo_birim_i) <= BIRIM_SAYISI);
        birim_hatasi  = cyo_gecerli_i && (int'(cyo_birim_i) > BIRIM_SAYISI);
        rd_izlenir    = cyo_rd_yaz_i
                      && (cyo_rd_adres_i != '0)
                      && (int'(cyo_rd_adres_i) < YAZMAC_SAYISI);
        raw_rs1 = cyo_rs1_kullan_i && !hazir[cyo_rs1_adres_i];
        raw_rs2 = cyo_rs2_kullan_i && !hazir[cyo_rs2_adres_i];
        waw     = cyo_rd_yaz_i && (cyo_rd_adres_i != '0) && !hazir[cyo_rd_adres_i];
    end

    // Capacity hazard: target unit is full and does not retire anything this cycle.
    always_comb begin
        kapasite_dolu = 1'b0;
        for (int k = 0; k < BIRIM_SAYISI; k++) begin
            if ((cyo_birim_i == BIRIM_BIT'(k + 1))
                && (sayac_q[k] == SAYAC_MAKS)
                && !tamam_gecerli[k]) begin
                kapasite_dolu = 1'b1;
            end
        end
    end

    // Stall and issue handshake; both forced low while reset is held.
    always_comb begin
        durdur_ham   = cyo_gecerli_i && (raw_rs1 || raw_rs2 || waw || kapasite_dolu);
        yayin        = rst_i && cyo_gecerli_i && !durdur_ham
                       && !ddb_durdur_i && !ddb_bosalt_i;
        cyo_durdur_o = rst_i && durdur_ham;
        cyo_yayin_o  = yayin;
    end

    // Pending/owner update: completions clear first, then an issue may re-set.
    always_comb begin
        bekliyor_d = bekliyor_q & ~tamamlaniyor;
        for (int r = 0; r < DERIN; r++) begin
            sahip_d[r] = sahip_q[r];
        end
        if (yayin && birim_gecerli && rd_izlenir) begin
            bekliyor_d[cyo_rd_adres_i] = 1'b1;
            sahip_d[cyo_rd_adres_i]    = cyo_birim_i;
        end
        bekliyor_d[0] = 1'b0;
    end

    // Per-unit outstanding counters, saturating at both ends.
    always_comb begin
        for (int k = 0; k < BIRIM_SAYISI; k++) begin
            sayac_d[k] = sayac_q[k];
            if (yayin && (cyo_birim_i == BIRIM_BIT'(k + 1)) && !tamam_gecerli[k]) begin
                if (sayac_q[k] != SAYAC_MAKS) begin
                    sayac_d[k] = sayac_q[k] + SAYAC_BIR;
                end
            end else if (tamam_gecerli[k]
                         && !(yayin && (cyo_birim_i == BIRIM_BIT'(k + 1)))) begin
                if (sayac_q[k] != '0) begin
                    sayac_d[k] = sayac_q[k] - SAYAC_BIR;
                end
            end
        end
    end

    // Idle flag follows the next counter values; error flag is sticky.
    always_comb begin
        bos_d = 1'b1;
        for (int k = 0; k < BIRIM_SAYISI; k++) begin
            if (sayac_d[k] != '0) begin
                bos_d = 1'b0;
            end
        end
        hata_d = hata_q || birim_hatasi || (|sahip_hatasi) || (|bos_sayac_hatasi);
    end

    // State registers; reset discards all tracking immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bekliyor_q <= '0;
            for (int r = 0; r < DERIN; r++) begin
                sahip_q[r] <= '0;
            end
            for (int k = 0; k < BIRIM_SAYISI; k++) begin
                sayac_q[k] <= '0;
            end
            hata_q <= 1'b0;
            bos_q  <= 1'b1;
        end else begin
            bekliyor_q <= bekliyor_d;
            for (int r = 0; r < DERIN; r++) begin
                sahip_q[r] <= sahip_d[r];
            end
            for (int k = 0; k < BIRIM_SAYISI; k++) begin
                sayac_q[k] <= sayac_d[k];
            end
            hata_q <= hata_d;
            bos_q  <= bos_d;
        end
    end

    assign bos_o  = bos_q;
    assign hata_o = hata_q;

endmodule

// File: tb/tb_yazmac_skor_tablosu.sv
// Self-checking bench for yazmac_skor_tablosu: a table of input/expected-output
// records streamed through a scoreboard queue, followed by a reset-mid-stream
// sequence. Combinational outputs and state outputs are sampled mid-cycle.
`timescale 1ns/1ps

module tb_yazmac_skor_tablosu;

    logic        clk_i;
    logic        rst_i;
    logic        cyo_gecerli_i;
    logic [4:0]  cyo_rs1_adres_i;
    logic        cyo_rs1_kullan_i;
    logic [4:0]  cyo_rs2_adres_i;
    logic        cyo_rs2_kullan_i;
    logic [4:0]  cyo_rd_adres_i;
    logic        cyo_rd_yaz_i;
    logic [1:0]  cyo_birim_i;
    logic        ddb_durdur_i;
    logic        ddb_bosalt_i;
    logic        cyo_durdur_o;
    logic        cyo_yayin_o;
    logic [2:0]  gy_tamam_i;
    logic [14:0] gy_rd_adres_i;
    logic [8:0]  bekleyen_sayisi_o;
    logic        bos_o;
    logic        hata_o;

    yazmac_skor_tablosu dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cyo_gecerli_i     (cyo_gecerli_i),
        .cyo_rs1_adres_i   (cyo_rs1_adres_i),
        .cyo_rs1_kullan_i  (cyo_rs1_kullan_i),
        .cyo_rs2_adres_i   (cyo_rs2_adres_i),
        .cyo_rs2_kullan_i  (cyo_rs2_kullan_i),
        .cyo_rd_adres_i    (cyo_rd_adres_i),
        .cyo_rd_yaz_i      (cyo_rd_yaz_i),
        .cyo_birim_i       (cyo_birim_i),
        .ddb_durdur_i      (ddb_durdur_i),
        .ddb_bosalt_i      (ddb_bosalt_i),
        .cyo_durdur_o      (cyo_durdur_o),
        .cyo_yayin_o       (cyo_yayin_o),
        .gy_tamam_i        (gy_tamam_i),
        .gy_rd_adres_i     (gy_rd_adres_i),
        .bekleyen_sayisi_o (bekleyen_sayisi_o),
        .bos_o             (bos_o),
        .hata_o            (hata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       gec;
        logic [4:0] rs1;
        logic       rs1k;
        logic [4:0] rs2;
        logic       rs2k;
        logic [4:0] rd;
        logic       rdy;
        logic [1:0] birim;
        logic       dd;
        logic       bo;
        logic [2:0] tam;
        logic [4:0] g1;
        logic [4:0] g2;
        logic [4:0] g3;
        logic       e_dur;
        logic       e_yay;
        logic       e_bos;
        logic [2:0] e_c1;
        logic [2:0] e_c2;
        logic [2:0] e_c3;
        logic       e_hata;
    } vek_t;

    localparam int TABLO_N = 27;
    vek_t tablo [TABLO_N];
    vek_t sb_q [$];

    int vek_sayisi = 0;
    int hatali     = 0;

    function automatic vek_t v(
        input logic gec, input logic [4:0] rs1, input logic rs1k,
        input logic [4:0] rs2, input logic rs2k, input logic [4:0] rd, input logic rdy,
        input logic [1:0] birim, input logic dd, input logic bo,
        input logic [2:0] tam, input logic [4:0] g1, input logic [4:0] g2, input logic [4:0] g3,
        input logic e_dur, input logic e_yay, input logic e_bos,
        input logic [2:0] e_c1, input logic [2:0] e_c2, input logic [2:0] e_c3,
        input logic e_hata);
        vek_t x;
        x.gec = gec; x.rs1 = rs1; x.rs1k = rs1k; x.rs2 = rs2; x.rs2k = rs2k;
        x.rd = rd; x.rdy = rdy; x.birim = birim; x.dd = dd; x.bo = bo;
        x.tam = tam; x.g1 = g1; x.g2 = g2; x.g3 = g3;
        x.e_dur = e_dur; x.e_yay = e_yay; x.e_bos = e_bos;
        x.e_c1 = e_c1; x.e_c2 = e_c2; x.e_c3 = e_c3; x.e_hata = e_hata;
        return x;
    endfunction

    task automatic chk(input string ad, input int idx, input logic [7:0] gercek,
                       input logic [7:0] beklenen);
        vek_sayisi++;
        if (gercek !== beklenen) begin
            hatali++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", ad, idx, gercek, beklenen);
        end
    endtask

    task automatic bosta_sur();
        cyo_gecerli_i = 0; cyo_rs1_adres_i = 0; cyo_rs1_kullan_i = 0;
        cyo_rs2_adres_i = 0; cyo_rs2_kullan_i = 0; cyo_rd_adres_i = 0;
        cyo_rd_yaz_i = 0; cyo_birim_i = 0; ddb_durdur_i = 0; ddb_bosalt_i = 0;
        gy_tamam_i = 0; gy_rd_adres_i = 0;
    endtask

    // Drive one record, queue its expectations, then compare mid-cycle.
    task automatic uygula(input vek_t x, input int idx);
        vek_t y;
        cyo_gecerli_i    = x.gec;
        cyo_rs1_adres_i  = x.rs1;
        cyo_rs1_kullan_i = x.rs1k;
        cyo_rs2_adres_i  = x.rs2;
        cyo_rs2_kullan_i = x.rs2k;
        cyo_rd_adres_i   = x.rd;
        cyo_rd_yaz_i     = x.rdy;
        cyo_birim_i      = x.birim;
        ddb_durdur_i     = x.dd;
        ddb_bosalt_i     = x.bo;
        gy_tamam_i       = x.tam;
        gy_rd_adres_i    = {x.g3, x.g2, x.g1};
        sb_q.push_back(x);
        #4;
        if (sb_q.size() == 0) begin
            vek_sayisi++;
            hatali++;
            $display("FAIL scoreboard vec %0d: got empty queue, expected one entry", idx);
        end else begin
            y = sb_q.pop_front();
            chk("durdur", idx, {7'b0, cyo_durdur_o}, {7'b0, y.e_dur});
            chk("yayin",  idx, {7'b0, cyo_yayin_o},  {7'b0, y.e_yay});
            chk("bos",    idx, {7'b0, bos_o},        {7'b0, y.e_bos});
            chk("sayac1", idx, {5'b0, bekleyen_sayisi_o[2:0]}, {5'b0, y.e_c1});
            chk("sayac2", idx, {5'b0, bekleyen_sayisi_o[5:3]}, {5'b0, y.e_c2});
            chk("sayac3", idx, {5'b0, bekleyen_sayisi_o[8:6]}, {5'b0, y.e_c3});
            chk("hata",   idx, {7'b0, hata_o},       {7'b0, y.e_hata});
            $display("vec %0d: durdur=%0b yayin=%0b bos=%0b sayac=%0h hata=%0b",
                     idx, cyo_durdur_o, cyo_yayin_o, bos_o, bekleyen_sayisi_o, hata_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                gec rs1 k rs2 k rd rdy b dd bo tam  g1 g2 g3 | dur yay bos c1 c2 c3 hata
        tablo[0]  = v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b000, 0, 0,0,  0,0,1, 0,0,0, 0); // idle after reset
        tablo[1]  = v(1, 1,1, 0,0,  5,1, 1,0,0, 3'b000, 0, 0,0,  0,1,1, 0,0,0, 0); // load rd=5
        tablo[2]  = v(1, 1,1, 5,1,  3,1, 0,0,0, 3'b000, 0, 0,0,  1,0,0, 1,0,0, 0); // RAW on rs2
        tablo[3]  = v(1, 5,1, 0,0,  3,1, 0,0,0, 3'b000, 0, 0,0,  1,0,0, 1,0,0, 0); // RAW on rs1
        tablo[4]  = v(1, 5,1, 0,0,  3,1, 0,0,0, 3'b001, 5, 0,0,  0,1,0, 1,0,0, 0); // bypass release
        tablo[5]  = v(1, 0,1, 0,0,  6,1, 2,0,0, 3'b000, 0, 0,0,  0,1,1, 0,0,0, 0); // mul rd=6, rs1=x0
        tablo[6]  = v(1, 0,1, 0,0,  7,1, 2,0,0, 3'b000, 0, 0,0,  0,1,0, 0,1,0, 0);
        tablo[7]  = v(1, 0,1, 0,0,  8,1, 2,0,0, 3'b000, 0, 0,0,  0,1,0, 0,2,0, 0);
        tablo[8]  = v(1, 0,1, 0,0,  9,1, 2,0,0, 3'b000, 0, 0,0,  0,1,0, 0,3,0, 0);
        tablo[9]  = v(1, 0,1, 0,0, 10,1, 2,0,0, 3'b000, 0, 0,0,  1,0,0, 0,4,0, 0); // capacity stall
        tablo[10] = v(1, 0,1, 0,0, 10,1, 2,0,0, 3'b010, 0, 6,0,  0,1,0, 0,4,0, 0); // completes same cycle
        tablo[11] = v(1, 0,0, 0,0,  7,1, 1,0,0, 3'b000, 0, 0,0,  1,0,0, 0,4,0, 0); // WAW on 7
        tablo[12] = v(1, 0,0, 0,0,  7,1, 1,0,0, 3'b010, 0, 7,0,  0,1,0, 0,4,0, 0); // WAW released
        tablo[13] = v(1, 7,1, 0,0,  0,0, 0,0,0, 3'b000, 0, 0,0,  1,0,0, 1,3,0, 0); // 7 pending again
        tablo[14] = v(1, 7,1, 0,0,  0,0, 0,0,0, 3'b001, 7, 0,0,  0,1,0, 1,3,0, 0); // owned by unit 1
        tablo[15] = v(1, 0,0, 8,0, 11,1, 2,0,1, 3'b000, 0, 0,0,  0,0,0, 0,3,0, 0); // flush
        tablo[16] = v(1, 0,0, 8,0, 11,1, 2,1,0, 3'b000, 0, 0,0,  0,0,0, 0,3,0, 0); // external stall
        tablo[17] = v(1, 0,1, 0,0,  0,1, 2,0,0, 3'b000, 0, 0,0,  0,1,0, 0,3,0, 0); // mul rd=0
        tablo[18] = v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b000, 0, 0,0,  0,0,0, 0,4,0, 0);
        tablo[19] = v(1, 0,0, 0,0, 11,1, 2,1,0, 3'b000, 0, 0,0,  1,0,0, 0,4,0, 0); // stall ignores ddb
        tablo[20] = v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b010, 0, 8,0,  0,0,0, 0,4,0, 0); // drain unit 2
        tablo[21] = v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b010, 0, 9,0,  0,0,0, 0,3,0, 0);
        tablo[22] = v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b010, 0,10,0,  0,0,0, 0,2,0, 0);
        tablo[23] = v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b010, 0, 0,0,  0,0,0, 0,1,0, 0);
        tablo[24] = v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b000, 0, 0,0,  0,0,1, 0,0,0, 0); // all idle
        tablo[25] = v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b100, 0, 0,0,  0,0,1, 0,0,0, 0); // completion at 0
        tablo[26] = v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b000, 0, 0,0,  0,0,1, 0,0,0, 1); // sticky error

        bosta_sur();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        for (int i = 0; i < TABLO_N; i++) begin
            uygula(tablo[i], i);
        end

        // Reset in the middle of a stream with three registers pending.
        uygula(v(1, 0,0, 0,0,  5,1, 1,0,0, 3'b000, 0,0,0,  0,1,1, 0,0,0, 1), 100);
        uygula(v(1, 0,0, 0,0,  6,1, 2,0,0, 3'b000, 0,0,0,  0,1,0, 1,0,0, 1), 101);
        uygula(v(1, 0,0, 0,0, 12,1, 3,0,0, 3'b000, 0,0,0,  0,1,0, 1,1,0, 1), 102);
        uygula(v(1, 5,1, 0,0,  3,1, 0,0,0, 3'b000, 0,0,0,  1,0,0, 1,1,1, 1), 103);

        rst_i = 1'b0;
        #2;
        chk("rst_durdur", 104, {7'b0, cyo_durdur_o}, 8'd0);
        chk("rst_yayin",  104, {7'b0, cyo_yayin_o},  8'd0);
        chk("rst_bos",    104, {7'b0, bos_o},        8'd1);
        chk("rst_sayac",  104, bekleyen_sayisi_o[7:0], 8'd0);
        chk("rst_sayac3", 104, {7'b0, bekleyen_sayisi_o[8]}, 8'd0);
        chk("rst_hata",   104, {7'b0, hata_o},       8'd0);
        $display("vec 104: reset held durdur=%0b yayin=%0b bos=%0b sayac=%0h hata=%0b",
                 cyo_durdur_o, cyo_yayin_o, bos_o, bekleyen_sayisi_o, hata_o);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Stale completion for unit 1 after release: flagged, no state change.
        uygula(v(0, 0,0, 0,0,  0,0, 0,0,0, 3'b001, 5,0,0,  0,0,1, 0,0,0, 0), 105);
        uygula(v(1, 5,1, 0,0,  3,1, 0,0,0, 3'b000, 0,0,0,  0,1,1, 0,0,0, 1), 106);

        if (sb_q.size() != 0) begin
            vek_sayisi++;
            hatali++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vek_sayisi, hatali);
        $finish;
    end

endmodule
